// File: rtl/bf_host_pkg.sv
// Shared constants for the TinyBF UART host front-end: command/response
// bytes, controller state encoding and the status-byte helper.
package bf_host_pkg;

    localparam logic [7:0] CMD_PROG = 8'h50;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_STAT = 8'h53;

    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_TMO = 8'h54;

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [ST_W-1:0] ST_P_LEN     = 4'd1;
    localparam logic [ST_W-1:0] ST_P_DATA    = 4'd2;
    localparam logic [ST_W-1:0] ST_RESP      = 4'd3;
    localparam logic [ST_W-1:0] ST_RESP_WAIT = 4'd4;
    localparam logic [ST_W-1:0] ST_D_RD      = 4'd5;
    localparam logic [ST_W-1:0] ST_D_LAT     = 4'd6;
    localparam logic [ST_W-1:0] ST_D_TX      = 4'd7;
    localparam logic [ST_W-1:0] ST_D_WAIT    = 4'd8;
    localparam logic [ST_W-1:0] ST_RUN       = 4'd9;
    localparam logic [ST_W-1:0] ST_ESC_WAIT  = 4'd10;

    typedef enum logic [ST_W-1:0] {
        S_IDLE      = ST_IDLE,
        S_P_LEN     = ST_P_LEN,
        S_P_DATA    = ST_P_DATA,
        S_RESP      = ST_RESP,
        S_RESP_WAIT = ST_RESP_WAIT,
        S_D_RD      = ST_D_RD,
        S_D_LAT     = ST_D_LAT,
        S_D_TX      = ST_D_TX,
        S_D_WAIT    = ST_D_WAIT,
        S_RUN       = ST_RUN,
        S_ESC_WAIT  = ST_ESC_WAIT
    } state_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_GAP  = 2'd1,
        A_WAIT = 2'd2
    } arb_e;

    // {cpu busy, reserved 0, 6-bit program counter}
    function automatic logic [7:0] status_byte(input logic busy, input logic [5:0] pc);
        return {busy, 1'b0, pc};
    endfunction

endpackage

// File: rtl/bf_host_tx_arb.sv
// UART TX ownership: CPU passthrough in RUN, otherwise a single-shot send
// handshake (req -> start pulse -> busy wait -> done) for the host FSM.
module bf_host_tx_arb
    import bf_host_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_sel_i,
    input  logic       req_i,
    input  logic [7:0] req_data_i,
    output logic       sent_c,
    output logic       done_c,
    input  logic       tx_busy_i,
    input  logic [7:0] cpu_tx_data_i,
    input  logic       cpu_tx_start_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o
);

    arb_e       phase_q, phase_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q    <= A_IDLE;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // The GAP phase hides the cycle before the UART has seen the start pulse.
    always_comb begin
        phase_d    = phase_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        sent_c     = 1'b0;
        done_c     = 1'b0;
        unique case (phase_q)
            A_IDLE: begin
                if (req_i) begin
                    tx_data_d = req_data_i;
                    if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                        sent_c     = 1'b1;
                        phase_d    = A_GAP;
                    end
                end
            end
            A_GAP: phase_d = A_WAIT;
            A_WAIT: begin
                if (!tx_busy_i) begin
                    done_c  = 1'b1;
                    phase_d = A_IDLE;
                end
            end
            default: phase_d = A_IDLE;
        endcase
    end

    assign tx_data_o  = run_sel_i ? cpu_tx_data_i  : tx_data_q;
    assign tx_start_o = run_sel_i ? cpu_tx_start_i : tx_start_q;

endmodule

// File: rtl/bf_host_ctrl.sv
// TinyBF UART host command front-end (load / run / halt / dump / status).
// Optional load inter-byte timeout: define BF_HOST_PROG_TIMEOUT_EN.
module bf_host_ctrl
    import bf_host_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned TAPE_ADDR_W    = 4,
    parameter int unsigned INSTR_W        = 8,
    parameter logic [7:0]  ESC_BYTE       = 8'h1B,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_busy_i,
    input  logic [7:0]             cpu_tx_data_i,
    input  logic                   cpu_tx_start_i,
    output logic                   cpu_rx_valid_o,
    output logic                   cpu_start_o,
    output logic                   cpu_halt_o,
    input  logic                   cpu_busy_i,
    input  logic [ADDR_W-1:0]      cpu_pc_i,
    output logic                   prog_wen_o,
    output logic [ADDR_W-1:0]      prog_waddr_o,
    output logic [INSTR_W-1:0]     prog_wdata_o,
    output logic                   tape_ren_o,
    output logic [TAPE_ADDR_W-1:0] tape_raddr_o,
    input  logic [7:0]             tape_rdata_i,
    output logic                   run_mode_o,
    output logic                   host_busy_o
);

    state_e                 state_q, state_d;
    state_e                 ret_q, ret_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic [7:0]             remain_q, remain_d;
    logic [ADDR_W-1:0]      p_addr_q, p_addr_d;
    logic                   prog_wen_q, prog_wen_d;
    logic [ADDR_W-1:0]      prog_waddr_q, prog_waddr_d;
    logic [INSTR_W-1:0]     prog_wdata_q, prog_wdata_d;
    logic                   tape_ren_q, tape_ren_d;
    logic [TAPE_ADDR_W-1:0] tape_raddr_q, tape_raddr_d;
    logic                   cpu_start_q, cpu_start_d;
    logic                   cpu_halt_q, cpu_halt_d;
    logic                   run_mode_q, run_mode_d;
    logic                   host_busy_q, host_busy_d;
    logic                   req_c, sent_c, done_c, tmo_hit_c;

`ifdef BF_HOST_PROG_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_load_c;

    // Idle-cycle counter for the load phase; any received byte restarts it.
    assign in_load_c = (state_q == S_P_LEN) || (state_q == S_P_DATA);
    assign tmo_hit_c = in_load_c && !rx_valid_i &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (in_load_c && !rx_valid_i && !tmo_hit_c) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit_c  = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    assign req_c = (state_q == S_RESP) || (state_q == S_D_TX);

    bf_host_tx_arb u_tx_arb (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .run_sel_i      (run_mode_q),
        .req_i          (req_c),
        .req_data_i     (tx_byte_q),
        .sent_c         (sent_c),
        .done_c         (done_c),
        .tx_busy_i      (tx_busy_i),
        .cpu_tx_data_i  (cpu_tx_data_i),
        .cpu_tx_start_i (cpu_tx_start_i),
        .tx_data_o      (tx_data_o),
        .tx_start_o     (tx_start_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            tx_byte_q    <= 8'd0;
            remain_q     <= 8'd0;
            p_addr_q     <= '0;
            prog_wen_q   <= 1'b0;
            prog_waddr_q <= '0;
            prog_wdata_q <= '0;
            tape_ren_q   <= 1'b0;
            tape_raddr_q <= '0;
            cpu_start_q  <= 1'b0;
            cpu_halt_q   <= 1'b0;
            run_mode_q   <= 1'b0;
            host_busy_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            tx_byte_q    <= tx_byte_d;
            remain_q     <= remain_d;
            p_addr_q     <= p_addr_d;
            prog_wen_q   <= prog_wen_d;
            prog_waddr_q <= prog_waddr_d;
            prog_wdata_q <= prog_wdata_d;
            tape_ren_q   <= tape_ren_d;
            tape_raddr_q <= tape_raddr_d;
            cpu_start_q  <= cpu_start_d;
            cpu_halt_q   <= cpu_halt_d;
            run_mode_q   <= run_mode_d;
            host_busy_q  <= host_busy_d;
        end
    end

    // Responses go through RESP/RESP_WAIT, then land in ret_q (IDLE or RUN).
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        tx_byte_d    = tx_byte_q;
        remain_d     = remain_q;
        p_addr_d     = p_addr_q;
        prog_wen_d   = 1'b0;
        prog_waddr_d = prog_waddr_q;
        prog_wdata_d = prog_wdata_q;
        tape_raddr_d = tape_raddr_q;
        cpu_start_d  = 1'b0;
        cpu_halt_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    state_d = S_RESP;
                    ret_d   = S_IDLE;
                    case (rx_data_i)
                        CMD_PROG: state_d = S_P_LEN;
                        CMD_RUN: begin
                            cpu_start_d = 1'b1;
                            tx_byte_d   = RSP_OK;
                            ret_d       = S_RUN;
                        end
                        CMD_HALT: begin
                            cpu_halt_d = 1'b1;
                            tx_byte_d  = RSP_OK;
                        end
                        CMD_DUMP: begin
                            state_d      = S_D_RD;
                            tape_raddr_d = '0;
                        end
                        CMD_STAT: tx_byte_d = status_byte(cpu_busy_i, 6'(cpu_pc_i));
                        default:  tx_byte_d = RSP_ERR;
                    endcase
                end
            end
            S_P_LEN: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'd0) begin
                        tx_byte_d = RSP_OK; ret_d = S_IDLE; state_d = S_RESP;
                    end else begin
                        remain_d = rx_data_i;
                        p_addr_d = '0;
                        state_d  = S_P_DATA;
                    end
                end else if (tmo_hit_c) begin
                    tx_byte_d = RSP_TMO; ret_d = S_IDLE; state_d = S_RESP;
                end
            end
            S_P_DATA: begin
                if (rx_valid_i) begin
                    prog_wen_d   = 1'b1;
                    prog_waddr_d = p_addr_q;
                    prog_wdata_d = INSTR_W'(rx_data_i);
                    p_addr_d     = p_addr_q + ADDR_W'(1);
                    remain_d     = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        tx_byte_d = RSP_OK; ret_d = S_IDLE; state_d = S_RESP;
                    end
                end else if (tmo_hit_c) begin
                    tx_byte_d = RSP_TMO; ret_d = S_IDLE; state_d = S_RESP;
                end
            end
            S_RESP:      if (sent_c) state_d = S_RESP_WAIT;
            S_RESP_WAIT: if (done_c) state_d = ret_q;
            S_D_RD:      state_d = S_D_LAT;
            S_D_LAT: begin
                tx_byte_d = tape_rdata_i;
                state_d   = S_D_TX;
            end
            S_D_TX:      if (sent_c) state_d = S_D_WAIT;
            S_D_WAIT: begin
                if (done_c) begin
                    if (tape_raddr_q == '1) begin
                        tx_byte_d = RSP_OK; ret_d = S_IDLE; state_d = S_RESP;
                    end else begin
                        tape_raddr_d = tape_raddr_q + TAPE_ADDR_W'(1);
                        state_d      = S_D_RD;
                    end
                end
            end
            S_RUN: begin
                if (rx_valid_i && (rx_data_i == ESC_BYTE)) begin
                    cpu_halt_d = 1'b1;
                    state_d    = S_ESC_WAIT;
                end
            end
            S_ESC_WAIT: begin
                if (!tx_busy_i) begin
                    tx_byte_d = RSP_OK; ret_d = S_IDLE; state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Read strobe and mode flags are registered alongside the state.
        tape_ren_d  = (state_d == S_D_RD);
        run_mode_d  = (state_d == S_RUN);
        host_busy_d = (state_d != S_IDLE) && (state_d != S_RUN);
    end

    assign cpu_rx_valid_o = run_mode_q && rx_valid_i && (rx_data_i != ESC_BYTE);
    assign cpu_start_o    = cpu_start_q;
    assign cpu_halt_o     = cpu_halt_q;
    assign prog_wen_o     = prog_wen_q;
    assign prog_waddr_o   = prog_waddr_q;
    assign prog_wdata_o   = prog_wdata_q;
    assign tape_ren_o     = tape_ren_q;
    assign tape_raddr_o   = tape_raddr_q;
    assign run_mode_o     = run_mode_q;
    assign host_busy_o    = host_busy_q;

endmodule

// File: tb/tb_bf_host_ctrl.sv
// Self-checking bench for bf_host_ctrl: command table, load/wrap/dump/run
// sequences, TX and program-write scoreboards, reset abort.
module tb_bf_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_busy_i = 1'b0;
    logic [7:0] cpu_tx_data_i;
    logic       cpu_tx_start_i;
    logic       cpu_rx_valid_o, cpu_start_o, cpu_halt_o;
    logic       cpu_busy_i;
    logic [4:0] cpu_pc_i;
    logic       prog_wen_o;
    logic [4:0] prog_waddr_o;
    logic [7:0] prog_wdata_o;
    logic       tape_ren_o;
    logic [3:0] tape_raddr_o;
    logic [7:0] tape_rdata_i = 8'd0;
    logic       run_mode_o, host_busy_o;

    bf_host_ctrl #(
        .ADDR_W(5), .TAPE_ADDR_W(4), .INSTR_W(8), .ESC_BYTE(8'h1B), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
        .cpu_tx_data_i(cpu_tx_data_i), .cpu_tx_start_i(cpu_tx_start_i),
        .cpu_rx_valid_o(cpu_rx_valid_o), .cpu_start_o(cpu_start_o), .cpu_halt_o(cpu_halt_o),
        .cpu_busy_i(cpu_busy_i), .cpu_pc_i(cpu_pc_i),
        .prog_wen_o(prog_wen_o), .prog_waddr_o(prog_waddr_o), .prog_wdata_o(prog_wdata_o),
        .tape_ren_o(tape_ren_o), .tape_raddr_o(tape_raddr_o), .tape_rdata_i(tape_rdata_i),
        .run_mode_o(run_mode_o), .host_busy_o(host_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] cmd; logic busy; logic [4:0] pc; logic [7:0] rsp; int halts; } vec_t;

    int         n_checks = 0, n_pass = 0;
    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    logic [7:0] prog_mem[32];
    logic [7:0] tape_mem[16];
    int         n_start = 0, n_halt = 0, n_rxv = 0, n_wen = 0, n_ren = 0;
    int         busy_cnt = 0;
    logic       prev_start = 1'b0, prev_halt = 1'b0, prev_wen = 1'b0, prev_ren = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // UART TX model + output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_start_o) begin
            if (exp_tx.size() == 0) begin
                n_checks++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data_o);
            end else begin
                chk("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
            end
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy_i <= (busy_cnt > 0);
        if (prog_wen_o) begin
            n_wen++;
            chk("wen_single", 32'(prev_wen), 32'd0);
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected none",
                         prog_waddr_o, prog_wdata_o);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(prog_waddr_o), 32'(w.a));
                chk("wr_data", 32'(prog_wdata_o), 32'(w.d));
            end
            prog_mem[prog_waddr_o] = prog_wdata_o;
        end
        if (cpu_start_o) begin n_start++; chk("start_single", 32'(prev_start), 32'd0); end
        if (cpu_halt_o)  begin n_halt++;  chk("halt_single", 32'(prev_halt), 32'd0); end
        if (tape_ren_o)  begin n_ren++;   chk("ren_single", 32'(prev_ren), 32'd0); end
        if (cpu_rx_valid_o) n_rxv++;
        prev_start = cpu_start_o;
        prev_halt  = cpu_halt_o;
        prev_wen   = prog_wen_o;
        prev_ren   = tape_ren_o;
    end

    always @(posedge clk) begin
        if (tape_ren_o) tape_rdata_i <= tape_mem[tape_raddr_o];
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 3000 && (host_busy_o || exp_tx.size() != 0 || tx_busy_i)) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_busy"}, 32'(host_busy_o), 32'd0);
        chk({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_tx_data"}, 32'(tx_data_o), 32'd0);
        chk({name, "_pulses"}, 32'({tx_start_o, cpu_rx_valid_o, cpu_start_o, cpu_halt_o,
                                     prog_wen_o, tape_ren_o}), 32'd0);
        chk({name, "_addrs"}, 32'({prog_waddr_o, prog_wdata_o, tape_raddr_o}), 32'd0);
        chk({name, "_modes"}, 32'({run_mode_o, host_busy_o}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        wr_t  w;
        int   h0, s0, r0, v0, w0;
        vecs[0] = '{8'h7A, 1'b0, 5'd0,  8'h45, 0};
        vecs[1] = '{8'h53, 1'b1, 5'd5,  8'h85, 0};
        vecs[2] = '{8'h53, 1'b0, 5'd31, 8'h1F, 0};
        vecs[3] = '{8'h48, 1'b0, 5'd0,  8'h4B, 1};
        vecs[4] = '{8'h00, 1'b1, 5'd3,  8'h45, 0};
        vecs[5] = '{8'h1B, 1'b0, 5'd0,  8'h45, 0};
        vecs[6] = '{8'h70, 1'b0, 5'd0,  8'h45, 0};
        vecs[7] = '{8'h53, 1'b1, 5'd0,  8'h80, 0};
        for (int i = 0; i < 16; i++) tape_mem[i] = 8'(i + 'h10);
        for (int i = 0; i < 32; i++) prog_mem[i] = 8'h00;
        rst = 1'b1; rx_data_i = 8'd0; rx_valid_i = 1'b0;
        cpu_tx_data_i = 8'd0; cpu_tx_start_i = 1'b0; cpu_busy_i = 1'b0; cpu_pc_i = 5'd0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // single-byte command table
        for (int i = 0; i < 8; i++) begin
            cpu_busy_i = vecs[i].busy;
            cpu_pc_i   = vecs[i].pc;
            h0 = n_halt;
            exp_tx.push_back(vecs[i].rsp);
            send(vecs[i].cmd);
            wait_idle("vec");
            chk("vec_halts", 32'(n_halt - h0), 32'(vecs[i].halts));
        end

        // program load of three words
        w.a = 5'd0; w.d = 8'h2B; exp_wr.push_back(w);
        w.a = 5'd1; w.d = 8'h3E; exp_wr.push_back(w);
        w.a = 5'd2; w.d = 8'h2E; exp_wr.push_back(w);
        exp_tx.push_back(8'h4B);
        w0 = n_wen;
        send(8'h50); send(8'h03); send(8'h2B); send(8'h3E); send(8'h2E);
        wait_idle("load");
        chk("load_wen_count", 32'(n_wen - w0), 32'd3);

        // zero-length load
        exp_tx.push_back(8'h4B);
        w0 = n_wen;
        send(8'h50); send(8'h00);
        wait_idle("load0");
        chk("load0_wen_count", 32'(n_wen - w0), 32'd0);

        // 34 words into a 32-deep program wraps to address 0
        for (int i = 0; i < 34; i++) begin
            w.a = 5'(i % 32); w.d = 8'(8'h80 + i); exp_wr.push_back(w);
        end
        exp_tx.push_back(8'h4B);
        send(8'h50); send(8'd34);
        for (int i = 0; i < 34; i++) send(8'(8'h80 + i));
        wait_idle("wrap");
        chk("wrap_mem0", 32'(prog_mem[0]), 32'hA0);
        chk("wrap_mem1", 32'(prog_mem[1]), 32'hA1);
        chk("wrap_mem2", 32'(prog_mem[2]), 32'h82);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);

        // tape dump
        for (int i = 0; i < 16; i++) exp_tx.push_back(8'(i + 'h10));
        exp_tx.push_back(8'h4B);
        r0 = n_ren;
        send(8'h44);
        wait_idle("dump");
        chk("dump_ren_count", 32'(n_ren - r0), 32'd16);

        // run, passthrough both ways, escape
        s0 = n_start;
        exp_tx.push_back(8'h4B);
        send(8'h52);
        wait_idle("run");
        chk("run_start_count", 32'(n_start - s0), 32'd1);
        chk("run_mode_on", 32'(run_mode_o), 32'd1);
        v0 = n_rxv;
        send(8'h41);
        chk("run_rx_fwd", 32'(n_rxv - v0), 32'd1);
        exp_tx.push_back(8'h42);
        @(posedge clk); #1 cpu_tx_data_i = 8'h42; cpu_tx_start_i = 1'b1;
        @(posedge clk); #1 cpu_tx_start_i = 1'b0;
        repeat (6) @(posedge clk);
        chk("run_cpu_tx_left", 32'(exp_tx.size()), 32'd0);
        h0 = n_halt;
        exp_tx.push_back(8'h4B);
        send(8'h1B);
        wait_idle("esc");
        chk("esc_halt_count", 32'(n_halt - h0), 32'd1);
        chk("esc_rx_blocked", 32'(n_rxv - v0), 32'd1);
        chk("run_mode_off", 32'(run_mode_o), 32'd0);

        // CPU send outside RUN is ignored
        @(posedge clk); #1 cpu_tx_data_i = 8'h99; cpu_tx_start_i = 1'b1;
        @(negedge clk);
        chk("idle_cpu_tx_start", 32'(tx_start_o), 32'd0);
        @(posedge clk); #1 cpu_tx_start_i = 1'b0;

`ifdef BF_HOST_PROG_TIMEOUT_EN
        w.a = 5'd0; w.d = 8'h2B; exp_wr.push_back(w);
        exp_tx.push_back(8'h54);
        send(8'h50); send(8'h04); send(8'h2B);
        wait_idle("timeout");
        chk("timeout_wr_left", 32'(exp_wr.size()), 32'd0);
`endif

        // reset in the middle of a dump
        for (int i = 0; i < 16; i++) exp_tx.push_back(8'(i + 'h10));
        exp_tx.push_back(8'h4B);
        send(8'h44);
        repeat (25) @(posedge clk);
        #1 rst = 1'b1;
        exp_tx.delete();
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk); #1 rst = 1'b0;
        cpu_busy_i = 1'b0; cpu_pc_i = 5'd3;
        exp_tx.push_back(8'h03);
        send(8'h53);
        wait_idle("post_reset");
        chk("rxv_total", 32'(n_rxv), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bf_host_ctrl.md
Name: bf_host_ctrl

Overview:
UART host command front-end for the TinyBF CPU. It replaces the raw prog_mode/start/halt pins with a byte-level command protocol carrying these modes:
- program load
- run with RX/TX passthrough
- halt
- tape dump
- status

It sits between uart_rx/uart_tx and the control unit, program memory and tape memory read port, and owns the UART TX mux.

Parameters:
- ADDR_W, 5: program address width, 1..6.
- TAPE_ADDR_W, 4: tape address width; dump length is 2^TAPE_ADDR_W.
- INSTR_W, 8: program word width.
- ESC_BYTE, 8'h1B: byte that exits RUN mode.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout during load; used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle pulse, rx_data_i valid
- tx_data_o  out  8  byte to UART TX
- tx_start_o  out  1  one-cycle send pulse
- tx_busy_i  in  1  UART TX busy
- cpu_tx_data_i  in  8  CPU output byte
- cpu_tx_start_i  in  1  CPU send pulse
- cpu_rx_valid_o  out  1  gated rx_valid for CPU; CPU reads rx_data_i directly
- cpu_start_o  out  1  one-cycle start pulse
- cpu_halt_o  out  1  one-cycle halt pulse
- cpu_busy_i  in  1  CPU activity
- cpu_pc_i  in  ADDR_W  CPU program counter
- prog_wen_o  out  1  program memory write enable
- prog_waddr_o  out  ADDR_W  program write address
- prog_wdata_o  out  INSTR_W  program write data
- tape_ren_o  out  1  tape read enable
- tape_raddr_o  out  TAPE_ADDR_W  tape read address
- tape_rdata_i  in  8  tape data, valid one cycle after tape_ren_o
- run_mode_o  out  1  high in RUN
- host_busy_o  out  1  high in any state except IDLE and RUN

Behaviour:
- Reset:
  - All outputs 0 (tx_data_o 0, addresses 0); state IDLE.
  - Asserting reset mid-operation aborts everything. No partial pulses are emitted after reset.
- States: IDLE, P_LEN, P_DATA, RESP, RESP_WAIT, D_RD, D_LAT, D_TX, D_WAIT, RUN, ESC_WAIT.
- IDLE accepts command bytes on rx_valid_i:
  - 'P' (0x50): go to P_LEN.
  - 'R' (0x52): cpu_start_o pulse next cycle; send 'K'; then RUN.
  - 'H' (0x48): cpu_halt_o pulse next cycle; send 'K'.
  - 'D' (0x44): go to D_RD with address 0.
  - 'S' (0x53): send status {cpu_busy_i, 1'b0, pc zero-extended to 6 bits}, sampled on the command cycle.
  - Any other byte: send 'E' (0x45).
- P_LEN: the next byte is count L.
  - L=0: send 'K' immediately.
  - Otherwise go to P_DATA with addr=0, remaining=L.
- P_DATA: each rx byte produces prog_wen_o=1 for exactly one cycle, registered one cycle after rx_valid_i, with the current address and data. Then address increments modulo 2^ADDR_W.
  - L > depth overwrites from 0 (wrap), no error.
  - After the L-th byte, send 'K'.
- Send handshake (RESP/D_TX):
  - Drive tx_data_o and wait while tx_busy_i=1.
  - Pulse tx_start_o for one cycle.
  - Move to RESP_WAIT/D_WAIT, ignore tx_busy_i for one cycle, then wait for tx_busy_i=0.
- Dump:
  - D_RD pulses tape_ren_o with addr i.
  - D_LAT latches tape_rdata_i one cycle later.
  - D_TX sends the byte.
  - Repeats for i=0..2^TAPE_ADDR_W-1, then sends 'K'.
- RUN:
  - TX mux selects the CPU: tx_data_o=cpu_tx_data_i, tx_start_o=cpu_tx_start_i (combinational).
  - cpu_rx_valid_o = rx_valid_i & (rx_data_i != ESC_BYTE).
  - ESC_BYTE pulses cpu_halt_o next cycle and goes to ESC_WAIT. ESC_WAIT waits for tx_busy_i=0, then sends 'K' and returns to IDLE.
  - A cpu_tx_start_i coincident with ESC is still forwarded; cpu_tx_start_i after that cycle is dropped.
- Outside RUN: cpu_rx_valid_o=0, cpu_tx_start_i ignored. rx bytes arriving in RESP*, D_*, ESC_WAIT are dropped.
- Pulses cpu_start_o, cpu_halt_o, prog_wen_o and tape_ren_o are never high for two consecutive cycles.

Optional Feature:
- Macro BF_HOST_PROG_TIMEOUT_EN.
- Defined: a counter runs in P_LEN/P_DATA and clears on each rx_valid_i. On reaching TIMEOUT_CYCLES-1 the load aborts with no further writes, sends 'T' (0x54), and returns to IDLE; written words remain.
- Undefined: no counter, and load waits indefinitely.

Decomposition:
- Package bf_host_pkg holds:
  - command codes CMD_PROG/RUN/HALT/DUMP/STAT;
  - response codes RSP_OK 'K', RSP_ERR 'E', RSP_TMO 'T';
  - the state encoding localparams.
- Sub-module bf_host_tx_arb holds the TX mux plus the single-shot send handshake (req/done to the FSM).

Test Plan:
- Load: "P",0x03,'+','>','.' -> prog writes (0,'+'),(1,'>'),(2,'.'), one cycle each; then TX 'K'.
- Wrap: ADDR_W=2, "P",0x05 then bytes a..e -> writes at addresses 0,1,2,3,0; final word at 0 is e; TX 'K'.
- Dump: preload tape cells i=i+0x10, send "D" -> TX 0x10..0x1F in order, then 'K'; tape_ren_o pulses 16 times.
- Run/escape: "R" -> cpu_start_o pulse, 'K', run_mode_o=1. Then rx 0x41 -> cpu_rx_valid_o pulse; CPU sends 0x42 -> appears on tx. Then 0x1B -> cpu_halt_o pulse, no cpu_rx_valid_o, 'K', run_mode_o=0.
- Errors/status: rx 0x7A -> 'E'. "S" with cpu_busy_i=1, pc=5 -> 0x85.
- BF_HOST_PROG_TIMEOUT_EN, TIMEOUT_CYCLES=100: "P",0x04 plus one byte, then silence -> 'T' after 100 idle cycles, state IDLE; reset mid-dump -> all outputs 0, next "S" answered normally.
